// File: rtl/up_bus_pkg.sv
// Shared types and constants for the two-master up-bus arbiter.
package up_bus_pkg;

   localparam int UP_AW     = 14;
   localparam int UP_DW     = 32;
   localparam int NUM_SLOTS = 4;

   // Slot numbering doubles as the round-robin order; bit 0 set means a read channel.
   localparam logic [1:0] SLOT_M0W = 2'd0;
   localparam logic [1:0] SLOT_M0R = 2'd1;
   localparam logic [1:0] SLOT_M1W = 2'd2;
   localparam logic [1:0] SLOT_M1R = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // First pending slot strictly after 'last', wrapping; returns 'last' if only it is pending.
   function automatic logic [1:0] rr_pick(input logic [NUM_SLOTS-1:0] pend,
                                          input logic [1:0]           last);
      logic [1:0] cand;
      logic [1:0] pick;
      logic       found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= NUM_SLOTS; i++) begin
         cand = last + 2'(i);
         if (!found && pend[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/up_bus_arb_slot.sv
// One capture slot: latches a request, holds it pending until the arbiter clears it.
module up_bus_arb_slot
   import up_bus_pkg::*;
(
   input  logic             up_clk,
   input  logic             up_rstn,
   input  logic             i_req,
   input  logic [UP_AW-1:0] i_addr,
   input  logic [UP_DW-1:0] i_data,
   input  logic             i_clr,
   output logic             o_pending,
   output logic [UP_AW-1:0] o_addr,
   output logic [UP_DW-1:0] o_data,
   output logic             o_drop
);

   logic             r_pending;
   logic [UP_AW-1:0] r_addr;
   logic [UP_DW-1:0] r_data;
   logic             w_accept;

   // A slot being cleared this cycle is free to take a new request at the same time.
   assign w_accept  = i_req && (!r_pending || i_clr);
   assign o_drop    = i_req && r_pending && !i_clr;
   assign o_pending = r_pending;
   assign o_addr    = r_addr;
   assign o_data    = r_data;

   // Capture on an accepted request, otherwise drop the pending flag when cleared.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_pending <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
      end else begin
         if (w_accept) begin
            r_pending <= 1'b1;
            r_addr    <= i_addr;
            r_data    <= i_data;
         end else if (i_clr) begin
            r_pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/up_bus_arb.sv
// Round-robin arbiter sharing one up-bus slave between two masters, with a watchdog.
module up_bus_arb
   import up_bus_pkg::*;
#(
   parameter int unsigned     TIMEOUT_CYCLES = 32,
   parameter logic [UP_DW-1:0] TIMEOUT_DATA  = 32'hDEAD_DEAD
) (
   input  logic             up_clk,
   input  logic             up_rstn,
   input  logic             up_wreq_m0,
   input  logic [UP_AW-1:0] up_waddr_m0,
   input  logic [UP_DW-1:0] up_wdata_m0,
   output logic             up_wack_m0,
   input  logic             up_rreq_m0,
   input  logic [UP_AW-1:0] up_raddr_m0,
   output logic [UP_DW-1:0] up_rdata_m0,
   output logic             up_rack_m0,
   input  logic             up_wreq_m1,
   input  logic [UP_AW-1:0] up_waddr_m1,
   input  logic [UP_DW-1:0] up_wdata_m1,
   output logic             up_wack_m1,
   input  logic             up_rreq_m1,
   input  logic [UP_AW-1:0] up_raddr_m1,
   output logic [UP_DW-1:0] up_rdata_m1,
   output logic             up_rack_m1,
   output logic             up_wreq,
   output logic [UP_AW-1:0] up_waddr,
   output logic [UP_DW-1:0] up_wdata,
   input  logic             up_wack,
   output logic             up_rreq,
   output logic [UP_AW-1:0] up_raddr,
   input  logic [UP_DW-1:0] up_rdata,
   input  logic             up_rack,
   output logic             up_busy,
   output logic             up_timeout,
   output logic             up_drop
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

   arb_state_t       r_state;
   logic [1:0]       r_gnt;
   logic [1:0]       r_last;
   logic [7:0]       r_timer;
   logic             r_wreq;
   logic             r_rreq;
   logic [UP_AW-1:0] r_waddr;
   logic [UP_DW-1:0] r_wdata;
   logic [UP_AW-1:0] r_raddr;
   logic             r_wack_m0;
   logic             r_rack_m0;
   logic [UP_DW-1:0] r_rdata_m0;
   logic             r_wack_m1;
   logic             r_rack_m1;
   logic [UP_DW-1:0] r_rdata_m1;
   logic             r_busy;
   logic             r_timeout;
   logic             r_drop;

   logic [NUM_SLOTS-1:0] w_req;
   logic [UP_AW-1:0]     w_in_addr   [NUM_SLOTS];
   logic [UP_DW-1:0]     w_in_data   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] w_pending;
   logic [UP_AW-1:0]     w_slot_addr [NUM_SLOTS];
   logic [UP_DW-1:0]     w_slot_data [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] w_drop;
   logic [NUM_SLOTS-1:0] w_clr;
   logic [1:0]           w_pick;
   logic                 w_ack_match;
   logic                 w_expired;
   logic [UP_DW-1:0]     w_resp_data;

   // Channel inputs gathered into slot order; read slots carry no data.
   assign w_req = {up_rreq_m1, up_wreq_m1, up_rreq_m0, up_wreq_m0};
   assign w_in_addr[SLOT_M0W] = up_waddr_m0;
   assign w_in_addr[SLOT_M0R] = up_raddr_m0;
   assign w_in_addr[SLOT_M1W] = up_waddr_m1;
   assign w_in_addr[SLOT_M1R] = up_raddr_m1;
   assign w_in_data[SLOT_M0W] = up_wdata_m0;
   assign w_in_data[SLOT_M0R] = '0;
   assign w_in_data[SLOT_M1W] = up_wdata_m1;
   assign w_in_data[SLOT_M1R] = '0;

   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_clr[gi] = (r_state == ST_RESP) && (r_gnt == 2'(gi));
      up_bus_arb_slot u_slot (
         .up_clk    (up_clk),
         .up_rstn   (up_rstn),
         .i_req     (w_req[gi]),
         .i_addr    (w_in_addr[gi]),
         .i_data    (w_in_data[gi]),
         .i_clr     (w_clr[gi]),
         .o_pending (w_pending[gi]),
         .o_addr    (w_slot_addr[gi]),
         .o_data    (w_slot_data[gi]),
         .o_drop    (w_drop[gi])
      );
   end

   assign w_pick      = rr_pick(w_pending, r_last);
   // Only the ack of the granted type counts; the ack beats a simultaneous expiry.
   assign w_ack_match = r_gnt[0] ? up_rack : up_wack;
   assign w_expired   = (r_timer == TO_LIMIT);
   assign w_resp_data = w_ack_match ? up_rdata : TIMEOUT_DATA;

   // Arbiter FSM: grant, issue one slave request, wait for ack or watchdog, answer the master.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_state    <= ST_IDLE;
         r_gnt      <= SLOT_M0W;
         r_last     <= SLOT_M1R;
         r_timer    <= '0;
         r_wreq     <= 1'b0;
         r_rreq     <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_raddr    <= '0;
         r_wack_m0  <= 1'b0;
         r_rack_m0  <= 1'b0;
         r_rdata_m0 <= '0;
         r_wack_m1  <= 1'b0;
         r_rack_m1  <= 1'b0;
         r_rdata_m1 <= '0;
         r_busy     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_wreq     <= 1'b0;
         r_rreq     <= 1'b0;
         r_wack_m0  <= 1'b0;
         r_rack_m0  <= 1'b0;
         r_rdata_m0 <= '0;
         r_wack_m1  <= 1'b0;
         r_rack_m1  <= 1'b0;
         r_rdata_m1 <= '0;
         r_timeout  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|w_pending) begin
                  r_gnt   <= w_pick;
                  r_last  <= w_pick;
                  r_busy  <= 1'b1;
                  r_state <= ST_ISSUE;
                  if (w_pick[0]) begin
                     r_rreq  <= 1'b1;
                     r_raddr <= w_slot_addr[w_pick];
                  end else begin
                     r_wreq  <= 1'b1;
                     r_waddr <= w_slot_addr[w_pick];
                     r_wdata <= w_slot_data[w_pick];
                  end
               end
            end
            ST_ISSUE: begin
               r_timer <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_ack_match || w_expired) begin
                  r_state   <= ST_RESP;
                  r_timeout <= !w_ack_match;
                  case (r_gnt)
                     SLOT_M0W: r_wack_m0 <= 1'b1;
                     SLOT_M0R: begin
                        r_rack_m0  <= 1'b1;
                        r_rdata_m0 <= w_resp_data;
                     end
                     SLOT_M1W: r_wack_m1 <= 1'b1;
                     default: begin
                        r_rack_m1  <= 1'b1;
                        r_rdata_m1 <= w_resp_data;
                     end
                  endcase
               end else begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Discarded requests from any slot collapse into one registered pulse.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) r_drop <= 1'b0;
      else          r_drop <= |w_drop;
   end

   assign up_wreq     = r_wreq;
   assign up_waddr    = r_waddr;
   assign up_wdata    = r_wdata;
   assign up_rreq     = r_rreq;
   assign up_raddr    = r_raddr;
   assign up_wack_m0  = r_wack_m0;
   assign up_rack_m0  = r_rack_m0;
   assign up_rdata_m0 = r_rdata_m0;
   assign up_wack_m1  = r_wack_m1;
   assign up_rack_m1  = r_rack_m1;
   assign up_rdata_m1 = r_rdata_m1;
   assign up_busy     = r_busy;
   assign up_timeout  = r_timeout;
   assign up_drop     = r_drop;

endmodule

// File: tb/tb_up_bus_arb.sv
// Self-checking bench for up_bus_arb: directed scenarios plus randomized traffic vs a cycle-count model.
`timescale 1ns/1ps
module tb_up_bus_arb;
   import up_bus_pkg::*;

   localparam int          T     = 8;
   localparam logic [31:0] TDATA = 32'hDEAD_DEAD;

   logic        up_clk  = 1'b0;
   logic        up_rstn = 1'b0;
   logic [3:0]  t_req;
   logic [13:0] t_addr  [4];
   logic [31:0] t_wdata [4];

   logic        up_wack_m0, up_rack_m0, up_wack_m1, up_rack_m1;
   logic [31:0] up_rdata_m0, up_rdata_m1;
   logic        up_wreq, up_rreq, up_busy, up_timeout, up_drop;
   logic [13:0] up_waddr, up_raddr;
   logic [31:0] up_wdata;
   logic        s_wack, s_rack;
   logic [31:0] s_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 up_clk = ~up_clk;

   up_bus_arb #(.TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TDATA)) dut (
      .up_clk(up_clk), .up_rstn(up_rstn),
      .up_wreq_m0(t_req[0]), .up_waddr_m0(t_addr[0]), .up_wdata_m0(t_wdata[0]), .up_wack_m0(up_wack_m0),
      .up_rreq_m0(t_req[1]), .up_raddr_m0(t_addr[1]), .up_rdata_m0(up_rdata_m0), .up_rack_m0(up_rack_m0),
      .up_wreq_m1(t_req[2]), .up_waddr_m1(t_addr[2]), .up_wdata_m1(t_wdata[2]), .up_wack_m1(up_wack_m1),
      .up_rreq_m1(t_req[3]), .up_raddr_m1(t_addr[3]), .up_rdata_m1(up_rdata_m1), .up_rack_m1(up_rack_m1),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(s_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(s_rdata), .up_rack(s_rack),
      .up_busy(up_busy), .up_timeout(up_timeout), .up_drop(up_drop)
   );

   function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- slave responder ----------------
   int          rsp_k    = 1;   // fixed ack delay after the slave request; 0 = never ack
   bit          rsp_rand = 1'b0;
   logic        inj_rack = 1'b0;
   logic        r_wack_s = 1'b0, r_rack_s = 1'b0;
   int          cnt      = 0;
   bit          cnt_rd   = 1'b0;
   logic [13:0] cur_raddr = '0;

   assign s_wack = r_wack_s;
   assign s_rack = r_rack_s | inj_rack;

   always @(posedge up_clk) begin
      #1;
      r_wack_s = 1'b0;
      r_rack_s = 1'b0;
      s_rdata  = rsp_rand ? $urandom : 32'h0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            if (cnt_rd) r_rack_s = 1'b1;
            else        r_wack_s = 1'b1;
            s_rdata = rsp_rand ? $urandom : {18'b0, cur_raddr};
         end
      end
      if (rsp_rand && $urandom_range(0, 15) == 0) begin
         r_wack_s = r_wack_s | 1'($urandom_range(0, 1));
         r_rack_s = r_rack_s | 1'($urandom_range(0, 1));
      end
      if (up_wreq || up_rreq) begin
         cnt_rd    = up_rreq;
         cur_raddr = up_raddr;
         if (rsp_rand) cnt = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, T + 3));
         else          cnt = rsp_k;
      end
   end

   // ---------------- behavioural model ----------------
   // Channels in round-robin order: m0w, m0r, m1w, m1r. A transaction is tracked by the
   // cycle number of its slave request; acks count from one cycle after it, and the
   // watchdog fires in the (T+1)th cycle after it.
   logic        m_pend [4];
   logic [13:0] m_addr [4];
   logic [31:0] m_data [4];
   int          m_last, m_mode, m_gnt, m_s, m_cyc;   // m_mode: 0 free, 1 in flight, 2 answering
   logic        e_wreq, e_rreq, e_busy, e_timeout, e_drop;
   logic [13:0] e_waddr, e_raddr;
   logic [31:0] e_wdata, e_rdata0, e_rdata1;
   logic [3:0]  e_ack;

   function automatic bit is_read(input int c);
      return (c == 1) || (c == 3);
   endfunction

   always @(posedge up_clk or negedge up_rstn) begin
      int          clr, age, c;
      logic        ack;
      logic [31:0] rd;
      e_wreq = 1'b0; e_rreq = 1'b0; e_ack = '0; e_rdata0 = '0; e_rdata1 = '0;
      e_timeout = 1'b0; e_drop = 1'b0;
      if (!up_rstn) begin
         for (int i = 0; i < 4; i++) begin m_pend[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end
         m_last = 3; m_mode = 0; m_gnt = 0; m_s = 0;
         e_busy = 1'b0; e_waddr = '0; e_wdata = '0; e_raddr = '0;
      end else begin
         clr = (m_mode == 2) ? m_gnt : -1;
         if (m_mode == 0) begin
            for (int i = 1; i <= 4; i++) begin
               c = (m_last + i) % 4;
               if (m_mode == 0 && m_pend[c]) begin
                  m_gnt = c; m_last = c; m_mode = 1; m_s = m_cyc + 1; e_busy = 1'b1;
                  if (is_read(c)) begin e_rreq = 1'b1; e_raddr = m_addr[c]; end
                  else begin e_wreq = 1'b1; e_waddr = m_addr[c]; e_wdata = m_data[c]; end
               end
            end
         end else if (m_mode == 1) begin
            age = m_cyc - m_s;
            ack = is_read(m_gnt) ? s_rack : s_wack;
            if (age >= 1 && (ack || age == T + 1)) begin
               rd = ack ? s_rdata : TDATA;
               e_timeout = !ack;
               e_ack[m_gnt] = 1'b1;
               if (m_gnt == 1) e_rdata0 = rd;
               if (m_gnt == 3) e_rdata1 = rd;
               m_mode = 2;
            end
         end else begin
            m_mode = 0;
            e_busy = 1'b0;
         end
         for (int ch = 0; ch < 4; ch++) begin
            if (t_req[ch]) begin
               if (m_pend[ch] && ch != clr) e_drop = 1'b1;
               else begin m_pend[ch] = 1'b1; m_addr[ch] = t_addr[ch]; m_data[ch] = t_wdata[ch]; end
            end else if (ch == clr) begin
               m_pend[ch] = 1'b0;
            end
         end
         m_cyc++;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;
   always @(negedge up_clk) begin
      if (chk_en) begin
         cmp("wreq",     32'(up_wreq),     32'(e_wreq));
         cmp("waddr",    32'(up_waddr),    32'(e_waddr));
         cmp("wdata",    up_wdata,         e_wdata);
         cmp("rreq",     32'(up_rreq),     32'(e_rreq));
         cmp("raddr",    32'(up_raddr),    32'(e_raddr));
         cmp("wack_m0",  32'(up_wack_m0),  32'(e_ack[0]));
         cmp("rack_m0",  32'(up_rack_m0),  32'(e_ack[1]));
         cmp("wack_m1",  32'(up_wack_m1),  32'(e_ack[2]));
         cmp("rack_m1",  32'(up_rack_m1),  32'(e_ack[3]));
         cmp("rdata_m0", up_rdata_m0,      e_rdata0);
         cmp("rdata_m1", up_rdata_m1,      e_rdata1);
         cmp("busy",     32'(up_busy),     32'(e_busy));
         cmp("timeout",  32'(up_timeout),  32'(e_timeout));
         cmp("drop",     32'(up_drop),     32'(e_drop));
         if (|e_ack)
            $display("[TB] txn done: ack=%b rdata_m0=0x%08h rdata_m1=0x%08h timeout=%0b",
                     e_ack, e_rdata0, e_rdata1, e_timeout);
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge up_clk);
      #1;
      t_req    = '0;
      inj_rack = 1'b0;
   endtask

   task automatic mid();
      #3;
   endtask

   task automatic pulse(input int ch, input logic [13:0] a, input logic [31:0] d);
      t_req[ch]   = 1'b1;
      t_addr[ch]  = a;
      t_wdata[ch] = is_read(ch) ? 32'h0 : d;
   endtask

   task automatic do_reset();
      step();
      up_rstn = 1'b0;
      step();
      step();
      up_rstn = 1'b1;
   endtask

   initial begin
      int n_wr, n_dr, n_ack;
      t_req = '0;
      for (int i = 0; i < 4; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end
      step();
      chk_en = 1'b1;
      mid();
      cmp("reset_busy",  32'(up_busy), 32'd0);
      cmp("reset_wdata", up_wdata,     32'd0);
      do_reset();

      // m0 write with a one-cycle slave ack
      rsp_k = 1;
      step(); pulse(0, 14'h0040, 32'h1234_5678);
      step();
      step(); mid();
      cmp("t1_wreq",  32'(up_wreq),  32'd1);
      cmp("t1_waddr", 32'(up_waddr), 32'h0040);
      cmp("t1_wdata", up_wdata,      32'h1234_5678);
      step(); mid();
      cmp("t1_wack_early", 32'(up_wack_m0), 32'd0);
      step(); mid();
      cmp("t1_wack_m0", 32'(up_wack_m0), 32'd1);
      cmp("t1_wack_m1", 32'(up_wack_m1), 32'd0);
      cmp("t1_rack_m1", 32'(up_rack_m1), 32'd0);
      repeat (3) step();

      // all four channels at once after reset: order m0w, m0r, m1w, m1r
      do_reset();
      step();
      pulse(0, 14'h0100, 32'hAAAA_0000); pulse(1, 14'h00A0, 32'h0);
      pulse(2, 14'h0200, 32'hBBBB_0000); pulse(3, 14'h00A1, 32'h0);
      for (int o = 1; o <= 16; o++) begin
         step(); mid();
         case (o)
            2:  begin cmp("t2_g0_wreq", 32'(up_wreq), 32'd1); cmp("t2_g0_addr", 32'(up_waddr), 32'h0100); end
            6:  begin cmp("t2_g1_rreq", 32'(up_rreq), 32'd1); cmp("t2_g1_addr", 32'(up_raddr), 32'h00A0); end
            8:  begin cmp("t2_rack_m0", 32'(up_rack_m0), 32'd1); cmp("t2_rdata_m0", up_rdata_m0, 32'hA0);
                      cmp("t2_rack_m1_quiet", 32'(up_rack_m1), 32'd0); end
            10: begin cmp("t2_g2_wreq", 32'(up_wreq), 32'd1); cmp("t2_g2_addr", 32'(up_waddr), 32'h0200); end
            14: begin cmp("t2_g3_rreq", 32'(up_rreq), 32'd1); cmp("t2_g3_addr", 32'(up_raddr), 32'h00A1); end
            16: begin cmp("t2_rack_m1", 32'(up_rack_m1), 32'd1); cmp("t2_rdata_m1", up_rdata_m1, 32'hA1);
                      cmp("t2_rdata_m0_quiet", up_rdata_m0, 32'd0); end
            default: ;
         endcase
      end
      repeat (2) step();

      // m1 read never acked: watchdog; a late rack is then ignored
      rsp_k = 0;
      step(); pulse(3, 14'h0333, 32'h0);
      n_ack = 0;
      for (int o = 1; o <= 20; o++) begin
         step();
         if (o == 13) inj_rack = 1'b1;
         mid();
         if (o == 11) cmp("t3_timeout_early", 32'(up_timeout), 32'd0);
         if (o == 12) begin
            cmp("t3_timeout",  32'(up_timeout), 32'd1);
            cmp("t3_rack_m1",  32'(up_rack_m1), 32'd1);
            cmp("t3_rdata_m1", up_rdata_m1,     TDATA);
         end
         if (o == 13) cmp("t3_busy_off", 32'(up_busy), 32'd0);
         if (o >= 13 && up_rack_m1) n_ack++;
      end
      cmp("t3_late_ack_ignored", 32'(n_ack), 32'd0);

      // rack in the same cycle as expiry: ack wins
      rsp_k = T + 1;
      step(); pulse(3, 14'h0055, 32'h0);
      for (int o = 1; o <= 14; o++) begin
         step(); mid();
         if (o == 12) begin
            cmp("t5_rack_m1",  32'(up_rack_m1), 32'd1);
            cmp("t5_rdata_m1", up_rdata_m1,     32'h55);
            cmp("t5_no_timeout", 32'(up_timeout), 32'd0);
         end
      end

      // second m0 write while the first is pending: one drop, first one wins
      rsp_k = 1;
      step(); pulse(0, 14'h0111, 32'h1111_1111);
      step(); pulse(0, 14'h0222, 32'h2222_2222);
      n_wr = 0; n_dr = 0;
      for (int o = 2; o <= 14; o++) begin
         step(); mid();
         if (up_wreq) n_wr++;
         if (up_drop) n_dr++;
         if (o == 2) begin
            cmp("t4_drop",  32'(up_drop),  32'd1);
            cmp("t4_waddr", 32'(up_waddr), 32'h0111);
            cmp("t4_wdata", up_wdata,      32'h1111_1111);
         end
      end
      cmp("t4_wreq_count", 32'(n_wr), 32'd1);
      cmp("t4_drop_count", 32'(n_dr), 32'd1);

      // reset during WAIT: abandoned; pointer restarts at m0w
      rsp_k = 0;
      step(); pulse(0, 14'h0066, 32'h6666_6666);
      step(); step(); step();
      up_rstn = 1'b0;
      mid();
      cmp("t6_busy",  32'(up_busy),  32'd0);
      cmp("t6_waddr", 32'(up_waddr), 32'd0);
      cmp("t6_wdata", up_wdata,      32'd0);
      step(); step();
      up_rstn = 1'b1;
      rsp_k = 1;
      n_ack = 0;
      for (int o = 0; o < 12; o++) begin
         step(); mid();
         if (up_wack_m0) n_ack++;
      end
      cmp("t6_no_ack", 32'(n_ack), 32'd0);
      // last grant before reset was m0w; a restarted pointer still picks m0w ahead of m1r
      step(); pulse(3, 14'h0777, 32'h0); pulse(0, 14'h0078, 32'h7878_7878);
      for (int o = 1; o <= 8; o++) begin
         step(); mid();
         if (o == 2) cmp("t6_first_m0w", 32'(up_wreq), 32'd1);
         if (o == 6) begin
            cmp("t6_then_m1r", 32'(up_rreq),  32'd1);
            cmp("t6_m1r_addr", 32'(up_raddr), 32'h0777);
         end
      end

      // randomized traffic
      rsp_rand = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         step();
         if (!up_rstn) up_rstn = 1'b1;
         else if ($urandom_range(0, 999) == 0) up_rstn = 1'b0;
         for (int ch = 0; ch < 4; ch++)
            if ($urandom_range(0, 5) == 0) pulse(ch, 14'($urandom), $urandom);
      end
      rsp_rand = 1'b0;
      rsp_k    = 1;
      up_rstn  = 1'b1;
      repeat (60) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
